// File: rtl/xrad_hs_framer.sv
// Frames 64-bit XRAD high-speed words into header / payload [/ checksum] link frames.
// Optional checksum trailer enabled by defining XRAD_FRAMER_CSUM_EN.
module xrad_hs_framer #(
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic [15:0] drop_cnt,
  output logic        overflow
);

  // state | meaning
  // IDLE  | waiting for a full frame of payload in the FIFO
  // HDR   | presenting the header word (sop)
  // PAY   | presenting FIFO head, one pop per transfer
  // CSUM  | presenting XOR checksum (eop), checksum build only
`ifdef XRAD_FRAMER_CSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LEN_C    = CW'(FRAME_LEN);
  localparam logic [7:0]    LEN8     = 8'(FRAME_LEN);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

  state_t state, state_nx;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] pay_left;
  logic [7:0]    seq;
  logic [15:0]   hdr_drop;
  logic          full, push, pop, drop, tx_xfer, last_pay, frame_done, hdr_entry;

  assign full      = (count == DEPTH_C);
  assign tx_xfer   = tx_valid && tx_ready;
  assign pop       = (state == PAY) && tx_xfer;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;
  assign last_pay  = (pay_left == CW'(1));
  assign hdr_entry = (state == IDLE) && (state_nx == HDR);

  // FIFO storage carries no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Payload words remaining in the current frame; terminal count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_left <= '0;
    end else if (state == HDR && tx_xfer) begin
      pay_left <= LEN_C;
    end else if (pop) begin
      pay_left <= pay_left - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_drop <= '0;
      seq      <= '0;
    end else begin
      if (hdr_entry)  hdr_drop <= drop_cnt;
      if (frame_done) seq      <= seq + 8'd1;
    end
  end

`ifdef XRAD_FRAMER_CSUM_EN
  logic [63:0] csum;

  assign frame_done = (state == CSUM) && tx_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum ^ mem[rd_ptr];
    end else if (frame_done) begin
      csum <= '0;
    end
  end
`else
  assign frame_done = pop && last_pay;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (count >= LEN_C) state_nx = HDR;
      HDR:  if (tx_xfer) state_nx = PAY;
      PAY: begin
        if (pop && last_pay) begin
`ifdef XRAD_FRAMER_CSUM_EN
          state_nx = CSUM;
`else
          state_nx = IDLE;
`endif
        end
      end
`ifdef XRAD_FRAMER_CSUM_EN
      CSUM: if (tx_xfer) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state only, so they hold while the sink stalls.
  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    case (state)
      HDR: begin
        tx_valid = 1'b1;
        tx_sop   = 1'b1;
        tx_data  = {16'hA55A, seq, LEN8, hdr_drop, 16'h0000};
      end
      PAY: begin
        tx_valid = 1'b1;
        tx_data  = mem[rd_ptr];
`ifndef XRAD_FRAMER_CSUM_EN
        tx_eop   = last_pay;
`endif
      end
`ifdef XRAD_FRAMER_CSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_eop   = 1'b1;
        tx_data  = csum;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xrad_hs_framer.sv
// Directed bench for xrad_hs_framer; frame shape follows XRAD_FRAMER_CSUM_EN.
module tb_xrad_hs_framer;
  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 8;
`ifdef XRAD_FRAMER_CSUM_EN
  localparam int WPF = FRAME_LEN + 2;
`else
  localparam int WPF = FRAME_LEN + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [63:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop, overflow;
  logic [15:0] drop_cnt;

  xrad_hs_framer #(.FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_data [0:31];
  logic        cap_sop  [0:31];
  logic        cap_eop  [0:31];
  int          cap_cyc  [0:31];
  int          cap_n;
  logic [63:0] stall_data [0:15];
  logic        stall_vld  [0:15];
  int          n_stall;
  logic [63:0] exp_data [0:31];
  logic        exp_sop  [0:31];
  logic        exp_eop  [0:31];

  // Expected frame model written into exp_* starting at idx.
  function automatic void build_frame(input int idx, input logic [7:0] seq,
                                      input logic [15:0] drop, input logic [63:0] base);
    logic [63:0] cs;
    cs = '0;
    exp_data[idx] = {16'hA55A, seq, 8'(FRAME_LEN), drop, 16'h0000};
    exp_sop[idx]  = 1'b1;
    exp_eop[idx]  = 1'b0;
    for (int k = 1; k <= FRAME_LEN; k++) begin
      exp_data[idx+k] = base + 64'(k - 1);
      exp_sop[idx+k]  = 1'b0;
      exp_eop[idx+k]  = (WPF == FRAME_LEN + 1) && (k == FRAME_LEN);
      cs = cs ^ (base + 64'(k - 1));
    end
    if (WPF == FRAME_LEN + 2) begin
      exp_data[idx+FRAME_LEN+1] = cs;
      exp_sop[idx+FRAME_LEN+1]  = 1'b0;
      exp_eop[idx+FRAME_LEN+1]  = 1'b1;
    end
  endfunction

  task automatic push_words(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) tx_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = base + 64'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Records transferred words; stalls tx_ready for stall_len cycles once stall_after words moved.
  task automatic capture_frame(input int n, input int stall_after, input int stall_len,
                               input int max_cyc);
    cap_n   = 0;
    n_stall = 0;
    for (int c = 0; c < max_cyc && cap_n < n; c++) begin
      @(negedge clk);
      if (cap_n == stall_after && n_stall < stall_len) begin
        tx_ready = 1'b0;
        stall_data[n_stall] = tx_data;
        stall_vld[n_stall]  = tx_valid;
        n_stall++;
      end else begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          cap_data[cap_n] = tx_data;
          cap_sop[cap_n]  = tx_sop;
          cap_eop[cap_n]  = tx_eop;
          cap_cyc[cap_n]  = cyc;
          cap_n++;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 64'h0) begin errors++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
    checks++; if (tx_sop !== 1'b0 || tx_eop !== 1'b0) begin errors++; $display("FAIL reset_sop_eop got %b%b want 00", tx_sop, tx_eop); end
    checks++; if (drop_cnt !== 16'h0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_drop got %h/%b want 0000/0", drop_cnt, overflow); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b want 0", tx_valid); end
  endtask

  task automatic test_basic;
    int c0;
    push_words(64'd1, 4);
    c0 = cyc;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", tx_valid); end
    capture_frame(WPF, -1, 0, 50);
    checks++; if (cap_n !== WPF) begin errors++; $display("FAIL basic_len got %0d want %0d", cap_n, WPF); end
    checks++; if (cap_cyc[0] !== c0 + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", cap_cyc[0] - c0, 1); end
    checks++; if (cap_data[0] !== 64'hA55A_0004_0000_0000) begin errors++; $display("FAIL basic_hdr got %h want %h", cap_data[0], 64'hA55A_0004_0000_0000); end
    build_frame(0, 8'd0, 16'd0, 64'd1);
    for (int k = 0; k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_sop[k] !== exp_sop[k] || cap_eop[k] !== exp_eop[k]) begin
        errors++;
        $display("FAIL basic_word%0d got %h sop%b eop%b want %h sop%b eop%b", k, cap_data[k], cap_sop[k], cap_eop[k], exp_data[k], exp_sop[k], exp_eop[k]);
      end
    end
  endtask

  task automatic test_stall;
    push_words(64'h11, 4);
    capture_frame(WPF, 2, 5, 60);
    checks++; if (n_stall !== 5) begin errors++; $display("FAIL stall_cycles got %0d want 5", n_stall); end
    for (int k = 0; k < n_stall; k++) begin
      checks++;
      if (stall_data[k] !== 64'h12 || stall_vld[k] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d got %h v%b want %h v1", k, stall_data[k], stall_vld[k], 64'h12);
      end
    end
    checks++; if (cap_n !== WPF) begin errors++; $display("FAIL stall_len got %0d want %0d", cap_n, WPF); end
    build_frame(0, 8'd1, 16'd0, 64'h11);
    for (int k = 0; k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_sop[k] !== exp_sop[k] || cap_eop[k] !== exp_eop[k]) begin
        errors++;
        $display("FAIL stall_word%0d got %h sop%b eop%b want %h sop%b eop%b", k, cap_data[k], cap_sop[k], cap_eop[k], exp_data[k], exp_sop[k], exp_eop[k]);
      end
    end
  endtask

  task automatic test_overflow;
    push_words(64'h21, 10);
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    capture_frame(2 * WPF, -1, 0, 100);
    checks++; if (cap_n !== 2 * WPF) begin errors++; $display("FAIL ovf_len got %0d want %0d", cap_n, 2 * WPF); end
    build_frame(0, 8'd2, 16'd0, 64'h21);
    build_frame(WPF, 8'd3, 16'd2, 64'h25);
    for (int k = 0; k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_sop[k] !== exp_sop[k] || cap_eop[k] !== exp_eop[k]) begin
        errors++;
        $display("FAIL ovf_word%0d got %h sop%b eop%b want %h sop%b eop%b", k, cap_data[k], cap_sop[k], cap_eop[k], exp_data[k], exp_sop[k], exp_eop[k]);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_still_sticky got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back;
    push_words(64'h31, 8);
    capture_frame(2 * WPF, -1, 0, 100);
    checks++; if (cap_n !== 2 * WPF) begin errors++; $display("FAIL b2b_len got %0d want %0d", cap_n, 2 * WPF); end
    checks++; if (cap_cyc[WPF] - cap_cyc[WPF-1] !== 2) begin errors++; $display("FAIL b2b_idle_gap got %0d want 2", cap_cyc[WPF] - cap_cyc[WPF-1]); end
    build_frame(0, 8'd4, 16'd2, 64'h31);
    build_frame(WPF, 8'd5, 16'd2, 64'h35);
    for (int k = 0; k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_sop[k] !== exp_sop[k] || cap_eop[k] !== exp_eop[k]) begin
        errors++;
        $display("FAIL b2b_word%0d got %h sop%b eop%b want %h sop%b eop%b", k, cap_data[k], cap_sop[k], cap_eop[k], exp_data[k], exp_sop[k], exp_eop[k]);
      end
    end
  endtask

  task automatic test_seq_wrap;
    logic [63:0] hdr;
    for (int i = 0; i < 251; i++) begin
      push_words(64'h1000 + 64'(i * 8), 4);
      capture_frame(WPF, -1, 0, 50);
      hdr = {16'hA55A, 8'(6 + i), 8'(FRAME_LEN), 16'd2, 16'h0000};
      checks++;
      if (cap_n !== WPF || cap_data[0] !== hdr) begin
        errors++;
        $display("FAIL seq_frame%0d got %h len %0d want %h len %0d", i, cap_data[0], cap_n, hdr, WPF);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic saw_valid;
    push_words(64'h41, 4);
    capture_frame(3, -1, 0, 50);
    checks++; if (cap_n !== 3) begin errors++; $display("FAIL mid_prefix got %0d want 3", cap_n); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_sop !== 1'b0 || tx_eop !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got %b%b%b want 000", tx_valid, tx_sop, tx_eop); end
    checks++; if (tx_data !== 64'h0) begin errors++; $display("FAIL mid_rst_data got %h want 0", tx_data); end
    checks++; if (drop_cnt !== 16'h0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_drop got %h/%b want 0000/0", drop_cnt, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resume got %b want 0", saw_valid); end
    push_words(64'h51, 4);
    capture_frame(WPF, -1, 0, 50);
    checks++; if (cap_n !== WPF) begin errors++; $display("FAIL mid_len got %0d want %0d", cap_n, WPF); end
    build_frame(0, 8'd0, 16'd0, 64'h51);
    for (int k = 0; k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_sop[k] !== exp_sop[k] || cap_eop[k] !== exp_eop[k]) begin
        errors++;
        $display("FAIL mid_word%0d got %h sop%b eop%b want %h sop%b eop%b", k, cap_data[k], cap_sop[k], cap_eop[k], exp_data[k], exp_sop[k], exp_eop[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_seq_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
